// File: rtl/cp_scoreboard.sv
// Register-dependency scoreboard gating the ID->EX issue handshake of the cprv32g pipeline.
// Latency: handshake outputs are combinational; counters, busy map and stall count update one cycle after the event.
// Backpressure: a RAW hazard or a full per-register writer counter drops valid_ex_o and instr_ready_id_o until it clears.
module cp_scoreboard #(
  parameter int MAX_PENDING = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_id_i,
  input  logic [4:0]  rs1_addr_id_i,
  input  logic [4:0]  rs2_addr_id_i,
  input  logic        rs1_used_id_i,
  input  logic        rs2_used_id_i,
  input  logic [4:0]  rd_addr_id_i,
  input  logic        rd_wen_id_i,
  input  logic        ready_ex_i,
  output logic        valid_ex_o,
  output logic        instr_ready_id_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_addr_i,
  output logic        stall_o,
  output logic [31:0] busy_regs_o,
  output logic [15:0] stall_cnt_o,
  output logic        err_o
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

  // x0 has no counter; cnt_view[0] is tied to zero so lookups by address need no special case.
  logic [CW-1:0] cnt_q    [1:31];
  logic [CW-1:0] cnt_d    [1:31];
  logic [CW-1:0] cnt_view [0:31];

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        err_q, err_d;

  logic        raw1, raw2, ovf, hazard, fire, wb_err;
  logic [31:1] inc_vec, dec_vec;

  // Flatten the counters into an address-indexable view with x0 reading as zero.
  always_comb begin
    cnt_view[0] = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_view[r] = cnt_q[r];
    end
  end

  // Hazard detection from registered counters only; no same-cycle writeback bypass.
  always_comb begin
    raw1   = rs1_used_id_i & (rs1_addr_id_i != 5'd0) & (cnt_view[rs1_addr_id_i] != '0);
    raw2   = rs2_used_id_i & (rs2_addr_id_i != 5'd0) & (cnt_view[rs2_addr_id_i] != '0);
    ovf    = rd_wen_id_i & (rd_addr_id_i != 5'd0) & (cnt_view[rd_addr_id_i] == CNT_MAX);
    hazard = raw1 | raw2 | ovf;
  end

  assign stall_o          = instr_valid_id_i & hazard;
  assign valid_ex_o       = instr_valid_id_i & ~hazard & ~rst;
  assign instr_ready_id_o = ready_ex_i & ~hazard & ~rst;
  assign fire             = valid_ex_o & ready_ex_i;

  // A writeback to a non-zero register with nothing outstanding is a protocol error.
  assign wb_err = wb_valid_i & (wb_rd_addr_i != 5'd0) & (cnt_view[wb_rd_addr_i] == '0);

  // Per-register increment on issue and decrement on retire; decrement never wraps below zero.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = fire & rd_wen_id_i & (rd_addr_id_i == 5'(r));
      dec_vec[r] = wb_valid_i & (wb_rd_addr_i == 5'(r)) & (cnt_q[r] != '0);
    end
  end

  // Next-state counters: simultaneous issue and retire on the same register cancel out.
  always_comb begin
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  // Stall-cycle counter saturates; error flag is sticky until reset.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    err_d = err_q | wb_err;
  end

  // State registers with synchronous reset discarding all pending writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  // Busy map: one bit per register with any writer in flight.
  always_comb begin
    busy_regs_o[0] = 1'b0;
    for (int r = 1; r < 32; r++) begin
      busy_regs_o[r] = (cnt_q[r] != '0);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_cp_scoreboard.sv
// Self-checking bench for cp_scoreboard: directed scenarios then randomized traffic.
// Latency: outputs compared every cycle against a per-register pending-count model.
// Backpressure: random ready_ex_i and hazards exercise stall and overflow gating.
module tb_cp_scoreboard;

  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_id_i;
  logic [4:0]  rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i, wb_rd_addr_i;
  logic        rs1_used_id_i, rs2_used_id_i, rd_wen_id_i, ready_ex_i, wb_valid_i;
  logic        valid_ex_o, instr_ready_id_o, stall_o, err_o;
  logic [31:0] busy_regs_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference state: pending writer count per architectural register.
  int pend [32];
  int stalls_m;
  bit err_m;

  always #5 clk = ~clk;

  cp_scoreboard #(.MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst(rst),
    .instr_valid_id_i(instr_valid_id_i),
    .rs1_addr_id_i(rs1_addr_id_i), .rs2_addr_id_i(rs2_addr_id_i),
    .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
    .rd_addr_id_i(rd_addr_id_i), .rd_wen_id_i(rd_wen_id_i),
    .ready_ex_i(ready_ex_i),
    .valid_ex_o(valid_ex_o), .instr_ready_id_o(instr_ready_id_o),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i),
    .stall_o(stall_o), .busy_regs_o(busy_regs_o),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setin(input bit iv, input int s1, input bit u1, input int s2, input bit u2,
                       input int rd, input bit wen, input bit rdy, input bit wbv, input int wbr);
    instr_valid_id_i = iv;
    rs1_addr_id_i = 5'(s1); rs1_used_id_i = u1;
    rs2_addr_id_i = 5'(s2); rs2_used_id_i = u2;
    rd_addr_id_i = 5'(rd);  rd_wen_id_i = wen;
    ready_ex_i = rdy;
    wb_valid_i = wbv; wb_rd_addr_i = 5'(wbr);
  endtask

  task automatic idle();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare all outputs to the model, then advance one clock and update the model.
  task automatic tick();
    bit blocked, e_valid, e_ready, e_stall, fired;
    logic [31:0] e_busy;
    int wr, rr;
    #1;
    blocked = (rs1_used_id_i && rs1_addr_id_i != 0 && pend[rs1_addr_id_i] > 0) ||
              (rs2_used_id_i && rs2_addr_id_i != 0 && pend[rs2_addr_id_i] > 0) ||
              (rd_wen_id_i && rd_addr_id_i != 0 && pend[rd_addr_id_i] >= MAXP);
    e_stall = instr_valid_id_i && blocked;
    e_valid = instr_valid_id_i && !blocked && !rst;
    e_ready = ready_ex_i && !blocked && !rst;
    e_busy = '0;
    for (int i = 1; i < 32; i++) if (pend[i] > 0) e_busy[i] = 1'b1;
    check("valid_ex", valid_ex_o, e_valid);
    check("instr_ready", instr_ready_id_o, e_ready);
    check("stall", stall_o, e_stall);
    check("busy_regs", busy_regs_o, e_busy);
    check("stall_cnt", stall_cnt_o, stalls_m);
    check("err", err_o, err_m);
    fired = e_valid && ready_ex_i;
    wr = wb_rd_addr_i;
    rr = rd_addr_id_i;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
      stalls_m = 0;
      err_m = 0;
    end else begin
      if (e_stall && stalls_m < 65535) stalls_m++;
      if (wb_valid_i && wr != 0) begin
        if (pend[wr] == 0) err_m = 1;
        else pend[wr]--;
      end
      if (fired && rd_wen_id_i && rr != 0) pend[rr]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) pend[i] = 0;
    stalls_m = 0;
    err_m = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy_regs_o, 32'h0);
    check("rst_stall_cnt", stall_cnt_o, 32'h0);
    check("rst_err", err_o, 32'h0);

    // addi x5 then writeback x5
    setin(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
    idle();
    check("addi_busy", busy_regs_o, 32'h0000_0020);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1, 5); tick();
    idle();
    check("addi_wb_busy", busy_regs_o, 32'h0);
    check("addi_err", err_o, 32'h0);

    // RAW stall for 4 cycles plus the writeback cycle
    do_reset();
    setin(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
    for (int k = 0; k < 4; k++) begin
      setin(1, 5, 1, 0, 0, 6, 0, 1, 0, 0);
      #1 check("raw_valid_lo", valid_ex_o, 32'h0);
      tick();
    end
    setin(1, 5, 1, 0, 0, 6, 0, 1, 1, 5);
    #1 check("raw_stall_wb", stall_o, 32'h1);
    tick();
    setin(1, 5, 1, 0, 0, 6, 0, 1, 0, 0);
    #1 check("raw_valid_hi", valid_ex_o, 32'h1);
    check("raw_stall_cnt", stall_cnt_o, 32'd5);
    tick();

    // Overflow on x7
    do_reset();
    for (int k = 0; k < 3; k++) begin
      setin(1, 0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
    end
    setin(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    #1 check("ovf_blocked", valid_ex_o, 32'h0);
    tick();
    setin(1, 0, 0, 0, 0, 7, 1, 1, 1, 7); tick();
    setin(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    #1 check("ovf_issue", valid_ex_o, 32'h1);
    tick();
    setin(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    #1 check("ovf_full_again", valid_ex_o, 32'h0);
    tick();

    // Simultaneous issue and writeback on x9
    do_reset();
    setin(1, 0, 0, 0, 0, 9, 1, 1, 0, 0); tick();
    setin(1, 0, 0, 0, 0, 9, 1, 1, 1, 9); tick();
    idle();
    check("simul_busy", busy_regs_o, 32'h0000_0200);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); tick();
    idle();
    check("simul_drain", busy_regs_o, 32'h0);
    check("simul_err", err_o, 32'h0);

    // x0 handling and sticky error
    do_reset();
    setin(1, 0, 0, 0, 0, 0, 1, 1, 1, 0); tick();
    setin(1, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    check("x0_busy", busy_regs_o, 32'h0);
    #1 check("x0_read_valid", valid_ex_o, 32'h1);
    tick();
    check("x0_wb_no_err", err_o, 32'h0);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1, 12); tick();
    idle();
    check("err_set", err_o, 32'h1);
    tick(); tick();
    check("err_sticky", err_o, 32'h1);

    // Reset mid-operation with x3 and x4 pending
    do_reset();
    setin(1, 0, 0, 0, 0, 3, 1, 1, 0, 0); tick();
    setin(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
    rst = 1'b1;
    setin(1, 3, 1, 0, 0, 8, 0, 1, 0, 0);
    #1 check("rst_valid_lo", valid_ex_o, 32'h0);
    check("rst_ready_lo", instr_ready_id_o, 32'h0);
    tick();
    rst = 1'b0;
    check("midrst_busy", busy_regs_o, 32'h0);
    #1 check("midrst_issue", valid_ex_o, 32'h1);
    tick();

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      setin($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
